// File: rtl/fp_pkg.sv
// Shared widths, encodings, state enum and operand/result types for the FP adder front end.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;

  localparam logic SUB = 1'b0;
  localparam logic ADD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } align_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_op_t;

  typedef struct packed {
    logic              sign_a;
    logic              sign_b;
    logic              operation;
    logic              eop;
    logic [EXP_W:0]    expdiff;
    logic [2:0]        compare;
    logic              swap;
    logic [EXP_W-1:0]  exp_large;
    logic [MANT_W-1:0] mant_large;
    logic              special;
  } fp_res_t;

  // Zero-exponent operands lose fraction and hidden bit, so denormals read as zero.
  function automatic fp_op_t unpack_op(input logic [31:0] x);
    fp_op_t r;
    r.sign = x[31];
    r.exp  = x[30:23];
    if (x[30:23] == 8'd0) begin
      r.mant = {MANT_W{1'b0}};
    end else begin
      r.mant = {1'b1, x[22:0], 3'b000};
    end
    return r;
  endfunction

  function automatic logic [30:0] flushed_mag(input logic [31:0] x);
    if (x[30:23] == 8'd0) begin
      return 31'd0;
    end else begin
      return x[30:0];
    end
  endfunction

endpackage

// File: rtl/fp_align_frontend_if.sv
// Operand/result handshake bundle; slave is the front end, master is the producer/consumer side.
interface fp_align_frontend_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       opA;
  logic [31:0]       opB;
  logic              op_in;
  logic              out_valid;
  logic              out_ready;
  logic              signA;
  logic              signB;
  logic              operation;
  logic              eop;
  logic [EXP_W:0]    expdiff;
  logic [2:0]        compare;
  logic              swap;
  logic [EXP_W-1:0]  exp_large;
  logic [MANT_W-1:0] mant_large;
  logic [MANT_W-1:0] mant_small;
  logic              special;

  modport slave (
    input  in_valid, opA, opB, op_in, out_ready,
    output in_ready, out_valid, signA, signB, operation, eop, expdiff,
           compare, swap, exp_large, mant_large, mant_small, special
  );

  modport master (
    output in_valid, opA, opB, op_in, out_ready,
    input  in_ready, out_valid, signA, signB, operation, eop, expdiff,
           compare, swap, exp_large, mant_large, mant_small, special
  );

endinterface

// File: rtl/fp_sticky_shifter.sv
// Combinational right shift by 0..SHIFT_STEP; every bit shifted out is ORed into bit 0.
module fp_sticky_shifter
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic [MANT_W-1:0] din,
  input  logic [3:0]        k,
  output logic [MANT_W-1:0] dout
);

  logic [MANT_W-1:0] shifted_s;
  logic [MANT_W-1:0] lost_s;

  always_comb begin
    shifted_s = din >> k;
    lost_s    = din & ~({MANT_W{1'b1}} << k);
    dout      = {shifted_s[MANT_W-1:1], shifted_s[0] | (|lost_s)};
  end

endmodule

// File: rtl/fp_align_frontend.sv
// FP add/sub front end: operand compare/swap, exponent difference and iterative sticky alignment.
module fp_align_frontend
  import fp_pkg::*;
#(
  parameter int SHIFT_STEP = 4,
  parameter int MAX_SHIFT  = 26
) (
  input logic                clk,
  input logic                rst,
  fp_align_frontend_if.slave io
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ALIGN = ALIGN;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]        state_q, state_d;
  logic [4:0]        rem_q, rem_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  fp_res_t           res_q, res_d;
  logic [MANT_W-1:0] mant_small_q, mant_small_d;

  fp_op_t            op_a_s, op_b_s;
  logic [30:0]       mag_a_s, mag_b_s;
  logic [EXP_W:0]    expdiff_s, absdiff_s;
  logic [4:0]        shift_s;
  logic [2:0]        compare_s;
  logic              special_s;
  logic [3:0]        k_s;
  logic [4:0]        rem_next_s;
  logic [MANT_W-1:0] shifted_s;

  fp_sticky_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shift (
    .din  (mant_small_q),
    .k    (k_s),
    .dout (shifted_s)
  );

  // Operand relationship decode, evaluated on the raw input bus.
  always_comb begin
    op_a_s    = unpack_op(io.opA);
    op_b_s    = unpack_op(io.opB);
    mag_a_s   = flushed_mag(io.opA);
    mag_b_s   = flushed_mag(io.opB);
    expdiff_s = {1'b0, io.opA[30:23]} - {1'b0, io.opB[30:23]};
    if (expdiff_s[EXP_W]) begin
      absdiff_s = 9'd0 - expdiff_s;
    end else begin
      absdiff_s = expdiff_s;
    end
    if (absdiff_s > 9'(MAX_SHIFT)) begin
      shift_s = 5'(MAX_SHIFT);
    end else begin
      shift_s = absdiff_s[4:0];
    end
    compare_s = {mag_a_s > mag_b_s, mag_a_s == mag_b_s, mag_a_s < mag_b_s};
    special_s = (io.opA[30:23] == 8'hFF) || (io.opB[30:23] == 8'hFF);
    if (rem_q < 5'(SHIFT_STEP)) begin
      k_s = rem_q[3:0];
    end else begin
      k_s = 4'(SHIFT_STEP);
    end
    rem_next_s = rem_q - {1'b0, k_s};
  end

  // Next-state and datapath load/shift control.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    out_valid_d  = out_valid_q;
    res_d        = res_q;
    mant_small_d = mant_small_q;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          res_d.sign_a     = op_a_s.sign;
          res_d.sign_b     = op_b_s.sign;
          res_d.operation  = io.op_in;
          res_d.eop        = op_a_s.sign ^ op_b_s.sign ^ (io.op_in == SUB);
          res_d.expdiff    = expdiff_s;
          res_d.compare    = compare_s;
          res_d.swap       = compare_s[0];
          res_d.exp_large  = compare_s[0] ? op_b_s.exp : op_a_s.exp;
          res_d.mant_large = compare_s[0] ? op_b_s.mant : op_a_s.mant;
          res_d.special    = special_s;
          mant_small_d     = compare_s[0] ? op_a_s.mant : op_b_s.mant;
          rem_d            = special_s ? 5'd0 : shift_s;
          state_d          = ST_ALIGN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        mant_small_d = shifted_s;
        rem_d        = rem_next_s;
        if (rem_next_s == 5'd0) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_ALIGN;
        end
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and result registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= 5'd0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      res_q        <= '0;
      mant_small_q <= {MANT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      res_q        <= res_d;
      mant_small_q <= mant_small_d;
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.signA      = res_q.sign_a;
  assign io.signB      = res_q.sign_b;
  assign io.operation  = res_q.operation;
  assign io.eop        = res_q.eop;
  assign io.expdiff    = res_q.expdiff;
  assign io.compare    = res_q.compare;
  assign io.swap       = res_q.swap;
  assign io.exp_large  = res_q.exp_large;
  assign io.mant_large = res_q.mant_large;
  assign io.mant_small = mant_small_q;
  assign io.special    = res_q.special;

endmodule

// File: tb/tb_fp_align_frontend.sv
// Directed scoreboard bench for fp_align_frontend: expected results are queued at drive time.
module tb_fp_align_frontend;

  typedef struct {
    logic [8:0]  expdiff;
    logic [2:0]  compare;
    logic        swap;
    logic        eop;
    logic [7:0]  exp_large;
    logic [26:0] mant_large;
    logic [26:0] mant_small;
    logic        special;
    logic        sign_a;
    logic        sign_b;
    logic        operation;
    int          lat;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  fp_align_frontend_if io ();

  fp_align_frontend #(.SHIFT_STEP(4), .MAX_SHIFT(26)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op);
    io.opA     = a;
    io.opB     = b;
    io.op_in   = op;
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic push(input logic [8:0] ed, input logic [2:0] cmp, input logic sw, input logic eo,
                      input logic [7:0] el, input logic [26:0] ml, input logic [26:0] ms,
                      input logic sp, input logic sa, input logic sb_, input logic opr, input int lat);
    exp_t e;
    e.expdiff = ed; e.compare = cmp; e.swap = sw; e.eop = eo; e.exp_large = el;
    e.mant_large = ml; e.mant_small = ms; e.special = sp; e.sign_a = sa; e.sign_b = sb_;
    e.operation = opr; e.lat = lat;
    sb.push_back(e);
  endtask

  // Wait for out_valid (bounded), then compare against the oldest scoreboard entry.
  task automatic wait_check(input string name);
    exp_t e;
    int   edges;
    edges = 0;
    while (!io.out_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_latency"}, 32'(edges), 32'(e.lat));
      chk({name, "_out_valid"}, 32'(io.out_valid), 32'd1);
      chk({name, "_expdiff"}, 32'(io.expdiff), 32'(e.expdiff));
      chk({name, "_compare"}, 32'(io.compare), 32'(e.compare));
      chk({name, "_swap"}, 32'(io.swap), 32'(e.swap));
      chk({name, "_eop"}, 32'(io.eop), 32'(e.eop));
      chk({name, "_exp_large"}, 32'(io.exp_large), 32'(e.exp_large));
      chk({name, "_mant_large"}, 32'(io.mant_large), 32'(e.mant_large));
      chk({name, "_mant_small"}, 32'(io.mant_small), 32'(e.mant_small));
      chk({name, "_special"}, 32'(io.special), 32'(e.special));
      chk({name, "_signs"}, 32'({io.signA, io.signB, io.operation}),
          32'({e.sign_a, e.sign_b, e.operation}));
      chk({name, "_in_ready_done"}, 32'(io.in_ready), 32'd0);
    end
  endtask

  task automatic release_result(input string name);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 32'(io.in_ready), 32'd1);
    chk({name, "_out_valid_after"}, 32'(io.out_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.opA   = 32'd0;
    io.opB   = 32'd0;
    io.op_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(io.in_ready), 32'd1);
    chk("reset_out_valid", 32'(io.out_valid), 32'd0);
    chk("reset_mant_small", 32'(io.mant_small), 32'd0);
    chk("reset_expdiff", 32'(io.expdiff), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.0 + 1.0
    push(9'h000, 3'b010, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h3F800000, 32'h3F800000, 1'b1);
    wait_check("one_plus_one");
    release_result("one_plus_one");

    // 1.0 + 0.25
    push(9'h002, 3'b100, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h3F800000, 32'h3E800000, 1'b1);
    wait_check("small_align");
    release_result("small_align");

    // 1.0 - 2^24: swap, 24-bit shift
    push(9'h1E8, 3'b001, 1'b1, 1'b1, 8'd151, 27'h4000000, 27'h0000004, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    drive(32'h3F800000, 32'h4B800000, 1'b0);
    wait_check("swap");
    release_result("swap");

    // exponent gap of 100 saturates at 26 with sticky
    push(9'h064, 3'b100, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b1, 7);
    drive(32'h3F800000, 32'h0D800000, 1'b1);
    wait_check("saturate");
    release_result("saturate");

    // infinity operand skips alignment
    push(9'h080, 3'b100, 1'b0, 1'b0, 8'd255, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h7F800000, 32'h3F800000, 1'b1);
    wait_check("special");
    release_result("special");

    // -2.0 + 1.0: effective subtraction from signs
    push(9'h001, 3'b100, 1'b0, 1'b1, 8'd128, 27'h4000000, 27'h2000000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    drive(32'hC0000000, 32'h3F800000, 1'b1);
    wait_check("neg_sign");
    release_result("neg_sign");

    // denormal flushes to zero and compares equal to +0
    push(9'h000, 3'b010, 1'b0, 1'b0, 8'd0, 27'h0000000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h00000001, 32'h00000000, 1'b1);
    wait_check("denorm_flush");
    release_result("denorm_flush");

    // backpressure: result held while in_valid pulses
    push(9'h002, 3'b100, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h3F800000, 32'h3E800000, 1'b1);
    wait_check("backpressure");
    for (int i = 0; i < 5; i++) begin
      io.opA = 32'h4B800000;
      io.opB = 32'h3F800000;
      io.in_valid = ~io.in_valid;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
      chk("bp_mant_small", 32'(io.mant_small), 32'h1000000);
      chk("bp_expdiff", 32'(io.expdiff), 32'h002);
    end
    io.in_valid = 1'b0;
    release_result("backpressure");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_capture", 32'(io.out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // reset during ALIGN of the swap case, then a clean transaction
    drive(32'h3F800000, 32'h4B800000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(io.in_ready), 32'd1);
    chk("midrst_mant_small", 32'(io.mant_small), 32'd0);
    chk("midrst_mant_large", 32'(io.mant_large), 32'd0);
    chk("midrst_expdiff", 32'(io.expdiff), 32'd0);
    chk("midrst_compare", 32'(io.compare), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(9'h000, 3'b010, 1'b0, 1'b0, 8'd127, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(32'h3F800000, 32'h3F800000, 1'b1);
    wait_check("post_reset");
    release_result("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
